udp_edge_event_encoder: RTL

//  Samples N_SIG 4-state signals and encodes each sampled transition into a
//  UDP-style edge code (prev,curr), e.g. (01), (0x), (?0). Each sample with any

---
 rtl/udp_edge_event_encoder_if.sv | 48 ++++
 rtl/udp_edge_event_encoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/udp_edge_event_encoder_if.sv
// udp_edge_event_encoder_if
//   Bundles the sampling inputs and the event stream of the edge event
//   encoder.
//   master : the encoder. It takes sample_en/sig_in/ev_ready/clr_ovf and
//            drives ev_* and overflow.
//   slave  : the producer/consumer that surrounds the encoder.
//   Signals:
//     sample_en  sample sig_in this cycle
//     sig_in     N_SIG 4-state values, 2 bits each (00=0 01=1 10=x 11=z)
//     ev_valid   head event valid
//     ev_ready   head accepted when ev_valid & ev_ready
//     ev_mask    per-signal edge mask
//     ev_prev    pre-edge raw values
//     ev_curr    post-edge raw values
//     ev_rise    rising edge flags, (01) (0x) (x1)
//     ev_fall    falling edge flags, (10) (1x) (x0)
//     ev_time    sample count at capture
//     overflow   sticky flag, set when an event was dropped
//     clr_ovf    clears overflow
interface udp_edge_event_encoder_if #(
    parameter int N_SIG = 4,
    parameter int TS_W  = 16
);
    logic                 sample_en;
    logic [2*N_SIG-1:0]   sig_in;
    logic                 ev_valid;
    logic                 ev_ready;
    logic [N_SIG-1:0]     ev_mask;
    logic [2*N_SIG-1:0]   ev_prev;
    logic [2*N_SIG-1:0]   ev_curr;
    logic [N_SIG-1:0]     ev_rise;
    logic [N_SIG-1:0]     ev_fall;
    logic [TS_W-1:0]      ev_time;
    logic                 overflow;
    logic                 clr_ovf;

    modport master (
        input  sample_en, sig_in, ev_ready, clr_ovf,
        output ev_valid, ev_mask, ev_prev, ev_curr, ev_rise, ev_fall,
               ev_time, overflow
    );

    modport slave (
        output sample_en, sig_in, ev_ready, clr_ovf,
        input  ev_valid, ev_mask, ev_prev, ev_curr, ev_rise, ev_fall,
               ev_time, overflow
    );
endinterface

// File: rtl/udp_edge_event_encoder.sv
// udp_edge_event_encoder
//   Samples N_SIG 4-state signals and turns every sample that contains at
//   least one transition into an event (mask, prev/curr raw values,
//   rise/fall flags, timestamp). Events are queued in a first-word-fall-
//   through FIFO of DEPTH entries and presented on a valid/ready stream.
//   Ports:
//     clk   clock, all state updates on the rising edge
//     rst   asynchronous active-high reset
//     bus   udp_edge_event_encoder_if.master (see interface header)
module udp_edge_event_encoder #(
    parameter int N_SIG = 4,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    udp_edge_event_encoder_if.master  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [N_SIG-1:0]   mask;
        logic [N_SIG-1:0]   rise;
        logic [N_SIG-1:0]   fall;
        logic [2*N_SIG-1:0] prev;
        logic [2*N_SIG-1:0] curr;
        logic [TS_W-1:0]    ts;
    } event_t;

    // z is folded onto x so that x<->z never counts as an edge.
    function automatic logic [1:0] norm(input logic [1:0] v);
        return v[1] ? 2'b10 : v;
    endfunction

    // Among real edges, the rising ones leave 0 or arrive at 1:
    // (01) (0x) (x1). Every other edge is falling.
    function automatic logic rises(input logic [1:0] p, input logic [1:0] c);
        return (norm(p) == 2'b00) || (norm(c) == 2'b01);
    endfunction

    logic [2*N_SIG-1:0] prev_q;
    logic [TS_W-1:0]    ts_q;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               ovf_q;
    event_t             mem [DEPTH];

    logic [N_SIG-1:0]   mask_p0;
    logic [N_SIG-1:0]   rise_p0;
    logic [N_SIG-1:0]   fall_p0;
    event_t             entry_p0;
    event_t             head_p1;
    logic               push, pop, wr_en, empty, full;

    // ---- stage p0: edge classification of the current sample ----
    always_comb begin
        mask_p0 = '0;
        rise_p0 = '0;
        fall_p0 = '0;
        for (int i = 0; i < N_SIG; i++) begin
            mask_p0[i] = norm(prev_q[2*i +: 2]) != norm(bus.sig_in[2*i +: 2]);
            rise_p0[i] = mask_p0[i] & rises(prev_q[2*i +: 2], bus.sig_in[2*i +: 2]);
            fall_p0[i] = mask_p0[i] & ~rise_p0[i];
        end
    end

    assign entry_p0 = '{mask: mask_p0, rise: rise_p0, fall: fall_p0,
                        prev: prev_q, curr: bus.sig_in, ts: ts_q};

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.sample_en & (|mask_p0);
    assign pop   = ~empty & bus.ev_ready;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= {N_SIG{2'b10}};
            ts_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (bus.sample_en) begin
                prev_q <= bus.sig_in;
                ts_q   <= ts_q + 1'b1;
            end
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            // A new drop wins over a simultaneous clear.
            if (push & full & ~pop)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    // ---- stage p1: FIFO storage and head presentation ----
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= entry_p0;
    end

    // Storage is not reset; the head is forced to zero while the FIFO is empty.
    assign head_p1 = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign bus.ev_valid = ~empty;
    assign bus.ev_mask  = head_p1.mask;
    assign bus.ev_rise  = head_p1.rise;
    assign bus.ev_fall  = head_p1.fall;
    assign bus.ev_prev  = head_p1.prev;
    assign bus.ev_curr  = head_p1.curr;
    assign bus.ev_time  = head_p1.ts;
    assign bus.overflow = ovf_q;
endmodule
